// File: rtl/mdu_iter_pkg.sv
// rtl/mdu_iter_pkg.sv - op codes and state encodings shared by the multiply/divide unit
package mdu_iter_pkg;

  // Operation codes presented on i_op
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // What the FIX cycle commits to HI/LO (or the flag)
  typedef enum logic [2:0] {
    FX_MUL  = 3'd0,
    FX_DIV  = 3'd1,
    FX_DZ   = 3'd2,
    FX_MTHI = 3'd3,
    FX_MTLO = 3'd4
  } fix_e;

endpackage

// File: rtl/mdu_iter_step.sv
// rtl/mdu_iter_step.sv - one shift-add / restoring-divide iteration on a shared adder
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_p_hi,
  input  logic [WIDTH-1:0] i_p_lo,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH-1:0] o_p_hi,
  output logic [WIDTH-1:0] o_p_lo
);

  logic [WIDTH:0] w_x;
  logic [WIDTH:0] w_y;
  logic [WIDTH:0] w_sum;
  logic           w_qbit;

  // Multiply adds the multiplicand when the outgoing multiplier bit is set and
  // shifts the product right; divide shifts the remainder left, trial-subtracts
  // the divisor and restores when the difference goes negative.
  always_comb begin
    w_x = i_is_div ? {i_p_hi, i_p_lo[WIDTH-1]} : {1'b0, i_p_hi};
    if (i_is_div) begin
      w_y = ~{1'b0, i_m};
    end else if (i_p_lo[0]) begin
      w_y = {1'b0, i_m};
    end else begin
      w_y = '0;
    end
    w_sum  = w_x + w_y + {{WIDTH{1'b0}}, i_is_div};
    w_qbit = ~w_sum[WIDTH];
    if (i_is_div) begin
      o_p_hi = w_qbit ? w_sum[WIDTH-1:0] : w_x[WIDTH-1:0];
      o_p_lo = {i_p_lo[WIDTH-2:0], w_qbit};
    end else begin
      o_p_hi = w_sum[WIDTH:1];
      o_p_lo = {w_sum[0], i_p_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative MIPS multiply/divide unit holding the HI/LO registers
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_div_by_zero
);

  state_e             r_state;
  fix_e               r_fix;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_p_hi;
  logic [WIDTH-1:0]   r_p_lo;
  logic [WIDTH-1:0]   r_m;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_dz;

  logic               w_is_mul;
  logic               w_is_div;
  logic               w_is_mt;
  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_step_hi;
  logic [WIDTH-1:0]   w_step_lo;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_neg;

  assign w_is_mul = (i_op == OP_MULT) || (i_op == OP_MULTU);
  assign w_is_div = (i_op == OP_DIV) || (i_op == OP_DIVU);
  assign w_is_mt  = (i_op == OP_MTHI) || (i_op == OP_MTLO);
  assign w_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
  assign w_a_neg  = w_signed & i_a[WIDTH-1];
  assign w_b_neg  = w_signed & i_b[WIDTH-1];
  // The most-negative value maps onto itself, which is its correct unsigned magnitude
  assign w_a_mag  = w_a_neg ? -i_a : i_a;
  assign w_b_mag  = w_b_neg ? -i_b : i_b;

  assign w_prod     = {r_p_hi, r_p_lo};
  assign w_prod_neg = -w_prod;

  // Multiply and divide share the iteration: the product is commutative, so the
  // rs magnitude always sits in P_lo and the rt magnitude is the fixed operand.
  mdu_step #(.WIDTH(WIDTH)) u_step (
    .i_is_div (r_fix == FX_DIV),
    .i_p_hi   (r_p_hi),
    .i_p_lo   (r_p_lo),
    .i_m      (r_m),
    .o_p_hi   (w_step_hi),
    .o_p_lo   (w_step_lo)
  );

  // Controller: accept, iterate, then commit the sign-corrected result in FIX.
  // Zero-divide and MTHI/MTLO skip RUN and commit one edge after acceptance.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_fix   <= FX_MUL;
      r_cnt   <= '0;
      r_p_hi  <= '0;
      r_p_lo  <= '0;
      r_m     <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start && (w_is_mul || w_is_div || w_is_mt)) begin
            r_dz    <= 1'b0;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_cnt   <= CNT_W'(WIDTH - 1);
            if (w_is_mt) begin
              r_p_lo  <= i_a;
              r_fix   <= (i_op == OP_MTHI) ? FX_MTHI : FX_MTLO;
              r_state <= ST_FIX;
            end else if (w_is_div && (i_b == '0)) begin
              r_fix   <= FX_DZ;
              r_state <= ST_FIX;
            end else begin
              r_p_hi  <= '0;
              r_p_lo  <= w_a_mag;
              r_m     <= w_b_mag;
              r_fix   <= w_is_div ? FX_DIV : FX_MUL;
              r_busy  <= 1'b1;
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          r_p_hi <= w_step_hi;
          r_p_lo <= w_step_lo;
          if (r_cnt == '0) begin
            r_busy  <= 1'b0;
            r_state <= ST_FIX;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_FIX: begin
          case (r_fix)
            FX_MUL: begin
              r_hi <= r_neg_q ? w_prod_neg[2*WIDTH-1:WIDTH] : r_p_hi;
              r_lo <= r_neg_q ? w_prod_neg[WIDTH-1:0] : r_p_lo;
            end
            FX_DIV: begin
              r_lo <= r_neg_q ? -r_p_lo : r_p_lo;
              r_hi <= r_neg_r ? -r_p_hi : r_p_hi;
            end
            FX_DZ:   r_dz <= 1'b1;
            FX_MTHI: r_hi <= r_p_lo;
            FX_MTLO: r_lo <= r_p_lo;
            default: ;
          endcase
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;
  assign o_div_by_zero = r_dz;

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - scoreboard bench for mdu_iter at WIDTH=32 and WIDTH=8
module tb_mdu_iter;
  import mdu_iter_pkg::*;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        s32_start, s8_start;
  logic [2:0]  s32_op, s8_op;
  logic [31:0] s32_a, s32_b;
  logic [7:0]  s8_a, s8_b;
  logic        o32_busy, o32_done, o32_dz;
  logic [31:0] o32_hi, o32_lo;
  logic        o8_busy, o8_done, o8_dz;
  logic [7:0]  o8_hi, o8_lo;

  int   total = 0;
  int   bad = 0;
  res_t q32[$];
  res_t q8[$];
  res_t st32 = '0;
  res_t st8 = '0;
  res_t e32, e8;
  logic p32 = 1'b0;
  logic p8 = 1'b0;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(32)) u_w32 (
    .i_clk(clk), .i_rst(rst), .i_start(s32_start), .i_op(s32_op), .i_a(s32_a), .i_b(s32_b),
    .o_busy(o32_busy), .o_done(o32_done), .o_hi(o32_hi), .o_lo(o32_lo), .o_div_by_zero(o32_dz)
  );

  mdu_iter #(.WIDTH(8)) u_w8 (
    .i_clk(clk), .i_rst(rst), .i_start(s8_start), .i_op(s8_op), .i_a(s8_a), .i_b(s8_b),
    .o_busy(o8_busy), .o_done(o8_done), .o_hi(o8_hi), .o_lo(o8_lo), .o_div_by_zero(o8_dz)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Architectural result of one op at width w, from plain integer arithmetic
  function automatic res_t ref_op(input int w, input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input res_t prev);
    res_t        r;
    logic [63:0] mask, ua, ub, p;
    longint      sa, sb;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    sa = longint'(ua);
    sb = longint'(ub);
    if (ua[w-1]) sa = sa - (longint'(1) << w);
    if (ub[w-1]) sb = sb - (longint'(1) << w);
    r = prev;
    r.dz = 1'b0;
    p = '0;
    case (op)
      OP_MULT, OP_MULTU: begin
        p = (op == OP_MULT) ? 64'(sa * sb) : ua * ub;
        r.hi = 32'((p >> w) & mask);
        r.lo = 32'(p & mask);
      end
      OP_DIV, OP_DIVU: begin
        if (ub == 64'd0) r.dz = 1'b1;
        else if (op == OP_DIV) begin
          r.lo = 32'(64'(sa / sb) & mask);
          r.hi = 32'(64'(sa % sb) & mask);
        end else begin
          r.lo = 32'((ua / ub) & mask);
          r.hi = 32'((ua % ub) & mask);
        end
      end
      OP_MTHI: r.hi = 32'(ua);
      OP_MTLO: r.lo = 32'(ua);
      default: r = prev;
    endcase
    return r;
  endfunction

  // Issue one op, check its latency and busy length; values are checked by the monitor.
  // intr>0 pulses a DIV start on the 32-bit unit that many cycles into the op.
  task automatic run_op(input bit w8, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit use_k, input logic [31:0] khi, input logic [31:0] klo, input int intr);
    res_t        r;
    int          w, lat, nbusy, elat;
    logic        dn;
    logic [31:0] bm;
    w  = w8 ? 8 : 32;
    bm = w8 ? {24'd0, b[7:0]} : b;
    r  = ref_op(w, op, a, b, w8 ? st8 : st32);
    if (use_k) begin
      r.hi = khi;
      r.lo = klo;
    end
    elat = (op <= OP_MULTU || (op <= OP_DIVU && bm != 32'd0)) ? w + 1 : 1;
    @(negedge clk);
    if (w8) begin
      s8_op = op; s8_a = a[7:0]; s8_b = b[7:0]; s8_start = 1'b1;
      q8.push_back(r); st8 = r;
    end else begin
      s32_op = op; s32_a = a; s32_b = b; s32_start = 1'b1;
      q32.push_back(r); st32 = r;
    end
    @(posedge clk); #1;
    s8_start = 1'b0;
    s32_start = 1'b0;
    lat = 0;
    nbusy = 0;
    dn = w8 ? o8_done : o32_done;
    while (!dn && lat < 200) begin
      nbusy += int'(w8 ? o8_busy : o32_busy);
      if (intr > 0 && lat == intr) begin
        s32_op = OP_DIV; s32_a = 32'd100; s32_b = 32'd3; s32_start = 1'b1;
      end else begin
        s32_start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      dn = w8 ? o8_done : o32_done;
    end
    s32_start = 1'b0;
    chk(w8 ? "latency8" : "latency32", 64'(lat), 64'(elat));
    chk(w8 ? "busy_len8" : "busy_len32", 64'(nbusy), 64'(elat == 1 ? 0 : w));
  endtask

  // Monitor: every done pops one expected result per unit
  always @(posedge clk) begin
    #1;
    if (o32_done) begin
      chk("done_pulse32", 64'(p32), 64'd0);
      if (q32.size() == 0) chk("unexpected_done32", 64'd1, 64'd0);
      else begin
        e32 = q32.pop_front();
        chk("hi32", 64'(o32_hi), 64'(e32.hi));
        chk("lo32", 64'(o32_lo), 64'(e32.lo));
        chk("dz32", 64'(o32_dz), 64'(e32.dz));
      end
    end
    if (o8_done) begin
      chk("done_pulse8", 64'(p8), 64'd0);
      if (q8.size() == 0) chk("unexpected_done8", 64'd1, 64'd0);
      else begin
        e8 = q8.pop_front();
        chk("hi8", 64'(o8_hi), 64'(e8.hi));
        chk("lo8", 64'(o8_lo), 64'(e8.lo));
        chk("dz8", 64'(o8_dz), 64'(e8.dz));
      end
    end
    p32 = o32_done;
    p8  = o8_done;
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    rst = 1'b1;
    s32_start = 1'b0; s32_op = '0; s32_a = '0; s32_b = '0;
    s8_start = 1'b0;  s8_op = '0;  s8_a = '0;  s8_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy32", 64'(o32_busy), 64'd0);
    chk("rst_done32", 64'(o32_done), 64'd0);
    chk("rst_hilo32", {o32_hi, o32_lo}, 64'd0);
    chk("rst_dz32", 64'(o32_dz), 64'd0);
    chk("rst_hilo8", 64'({o8_hi, o8_lo, o8_busy, o8_dz}), 64'd0);
    rst = 1'b0;

    run_op(0, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001, 0);
    run_op(0, OP_MULT,  32'hFFFFFFFD, 32'd7,        1, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
    run_op(0, OP_DIVU,  32'd7,        32'd2,        1, 32'd1,        32'd3,        0);
    run_op(0, OP_DIV,   32'hFFFFFFF9, 32'd2,        1, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run_op(0, OP_DIV,   32'h80000000, 32'hFFFFFFFF, 1, 32'h00000000, 32'h80000000, 0);
    run_op(0, OP_DIVU,  32'd5,        32'd0,        1, 32'h00000000, 32'h80000000, 0);

    // unrecognised op: nothing happens and the zero-divide flag survives
    @(negedge clk); s32_op = 3'd6; s32_start = 1'b1;
    @(posedge clk); #1 s32_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("badop_busy32", 64'(o32_busy), 64'd0);
    chk("badop_dz32", 64'(o32_dz), 64'd1);

    run_op(0, OP_MTLO, 32'h00001234, 32'd0, 1, 32'h00000000, 32'h00001234, 0);
    run_op(0, OP_MTHI, 32'hCAFEF00D, 32'd9, 0, 32'd0, 32'd0, 0);
    run_op(0, OP_MULT, 32'h12345678, 32'hFEDCBA98, 0, 32'd0, 32'd0, 10);

    // reset in the middle of a multiply aborts it without a done
    @(negedge clk); s32_op = OP_MULT; s32_a = 32'd11; s32_b = 32'd13; s32_start = 1'b1;
    @(posedge clk); #1 s32_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_busy32", 64'(o32_busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    st32 = '0;
    st8 = '0;
    chk("abort_busy32", 64'(o32_busy), 64'd0);
    chk("abort_hilo32", {o32_hi, o32_lo}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("abort_idle32", 64'(o32_busy), 64'd0);

    run_op(1, OP_MULT, 32'h80, 32'h80, 1, 32'h40, 32'h00, 0);
    run_op(1, OP_DIV,  32'h80, 32'hFF, 1, 32'h00, 32'h80, 0);

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 5));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 9) == 0) begin
        a = (i % 2 == 1) ? 32'h80 : 32'h80000000;
        b = 32'hFFFFFFFF;
      end
      run_op(i % 2 == 1, op, a, b, 0, 32'd0, 32'd0, 0);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("q32_empty", 64'(q32.size()), 64'd0);
    chk("q8_empty", 64'(q8.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
